// File: rtl/pc_next_unit.sv
// pc_next_unit
// ------------
// Program-counter stage. Holds the architectural PC and computes three
// values from it: the sequential successor (PC+4), the branch/JAL target
// (PC+imm) and the JALR target ((rs1+imm) with bit 0 cleared). It then
// registers the next PC using a fixed redirect priority:
//   trap > stall > aligned redirect > misaligned redirect (hold) > PC+4
// It also keeps a sticky misaligned-target flag together with the first
// offending address, and counts the cycles on which the PC register loaded.
//
// Ports:
//   clk              rising-edge clock
//   rst_n            synchronous active-low reset
//   stall_i          hold the PC (a trap still overrides it)
//   branch_taken_i   conditional branch resolved taken (target PC+imm)
//   jal_i            JAL redirect (target PC+imm)
//   jalr_i           JALR redirect (target (rs1+imm) & ~1), wins over jal/branch
//   trap_i           trap redirect to trap_vec_i, highest priority
//   imm_i            sign-extended immediate
//   rs1_i            rs1 operand for JALR
//   trap_vec_i       trap handler address
//   pc_o             current PC (registered)
//   pc_plus4_o       pc_o + 4, combinational link value
//   target_o         selected redirect target, combinational
//   misalign_o       sticky misaligned-target flag
//   misalign_addr_o  first misaligned target seen since the last trap/reset
//   adv_cnt_o        number of edges on which the PC register loaded
module pc_next_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              ALIGN_C      = 0,
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic             jal_i,
  input  logic             jalr_i,
  input  logic             trap_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  trap_vec_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  pc_plus4_o,
  output logic [XLEN-1:0]  target_o,
  output logic             misalign_o,
  output logic [XLEN-1:0]  misalign_addr_o,
  output logic [CNT_W-1:0] adv_cnt_o
);

  localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0]  LSB_MASK = ~(XLEN'(1));
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Architectural state
  logic [XLEN-1:0]  pc_q;
  logic             mis_q;
  logic [XLEN-1:0]  mis_addr_q;
  logic [CNT_W-1:0] cnt_q;

  // Next-state values
  logic [XLEN-1:0]  pc_d;
  logic             mis_d;
  logic [XLEN-1:0]  mis_addr_d;
  logic             pc_load;

  // Datapath
  logic [XLEN-1:0]  seq_pc;
  logic [XLEN-1:0]  br_tgt;
  logic [XLEN-1:0]  jr_sum;
  logic [XLEN-1:0]  jr_tgt;
  logic [XLEN-1:0]  tgt;
  logic             redirect;
  logic             tgt_mis;

  // All adds wrap modulo 2^XLEN; carries are discarded on purpose.
  assign seq_pc = pc_q + PC_STEP;
  assign br_tgt = pc_q + imm_i;
  assign jr_sum = rs1_i + imm_i;
  assign jr_tgt = jr_sum & LSB_MASK;

  assign tgt      = jalr_i ? jr_tgt : br_tgt;
  assign redirect = jalr_i | jal_i | branch_taken_i;

  // Alignment check. With compressed instructions every target is
  // already even (JALR clears bit 0, immediates are even), so nothing
  // can fault. Without them bit 1 of the target must be clear.
  generate
    if (ALIGN_C == 0) begin : g_align4
      assign tgt_mis = tgt[1];
    end else begin : g_align2
      assign tgt_mis = 1'b0;
    end
  endgenerate

  // Next-PC selection in priority order.
  always_comb begin
    pc_d       = pc_q;
    mis_d      = mis_q;
    mis_addr_d = mis_addr_q;
    pc_load    = 1'b0;

    if (trap_i) begin
      // Trap beats stall and clears the fault record.
      pc_d       = trap_vec_i;
      mis_d      = 1'b0;
      mis_addr_d = '0;
      pc_load    = 1'b1;
    end else if (stall_i) begin
      pc_d = pc_q;
    end else if (redirect) begin
      if (tgt_mis) begin
        // Faulting redirect: PC holds; only the first fault's address
        // is recorded until a trap or reset clears the flag.
        mis_d = 1'b1;
        if (!mis_q) begin
          mis_addr_d = tgt;
        end
      end else begin
        pc_d    = tgt;
        pc_load = 1'b1;
      end
    end else begin
      pc_d    = seq_pc;
      pc_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_VECTOR;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
      if (pc_load) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  assign pc_o            = pc_q;
  assign pc_plus4_o      = seq_pc;
  assign target_o        = tgt;
  assign misalign_o      = mis_q;
  assign misalign_addr_o = mis_addr_q;
  assign adv_cnt_o       = cnt_q;

endmodule
